// File: rtl/vga_sync_timing_param.sv
// Parametrised VGA raster timing generator: syncs, blank, lead-adjusted pixel request with X/Y,
// and frame/line/vblank event pulses. Every output is registered from the previous counter state.
module vga_sync_timing_param #(
   parameter int P_H_ACTIVE = 640,
   parameter int P_H_FP     = 16,
   parameter int P_H_SYNC   = 96,
   parameter int P_H_BP     = 48,
   parameter int P_V_ACTIVE = 480,
   parameter int P_V_FP     = 10,
   parameter int P_V_SYNC   = 2,
   parameter int P_V_BP     = 33,
   parameter bit P_HS_POL   = 1'b0,
   parameter bit P_VS_POL   = 1'b0,
   parameter int P_REQ_LEAD = 2,
   parameter int P_CNT_W    = 12
) (
   input  logic               iVGA_CLOCK,
   input  logic               inRESET,
   input  logic               iRESET_SYNC,
   output logic               oDATA_REQ,
   output logic [P_CNT_W-1:0] oDATA_REQ_X,
   output logic [P_CNT_W-1:0] oDATA_REQ_Y,
   output logic               oDISP_HSYNC,
   output logic               oDISP_VSYNC,
   output logic               oDISP_BLANK,
   output logic               oFRAME_START,
   output logic               oLINE_START,
   output logic               oVBLANK_START
);

   localparam int H_TOTAL     = P_H_SYNC + P_H_BP + P_H_ACTIVE + P_H_FP;
   localparam int V_TOTAL     = P_V_SYNC + P_V_BP + P_V_ACTIVE + P_V_FP;
   localparam int H_VIS_START = P_H_SYNC + P_H_BP;
   localparam int H_VIS_END   = H_VIS_START + P_H_ACTIVE;
   localparam int H_REQ_START = H_VIS_START - P_REQ_LEAD;
   localparam int H_REQ_END   = H_VIS_END - P_REQ_LEAD;
   localparam int V_VIS_START = P_V_SYNC + P_V_BP;
   localparam int V_VIS_END   = V_VIS_START + P_V_ACTIVE;
   // With no front porch the first non-visible line is line 0 of the next frame.
   localparam int V_VBL_LINE  = (P_V_FP == 0) ? 0 : V_VIS_END;

   localparam logic [P_CNT_W-1:0] C_H_LAST      = P_CNT_W'(H_TOTAL - 1);
   localparam logic [P_CNT_W-1:0] C_V_LAST      = P_CNT_W'(V_TOTAL - 1);
   localparam logic [P_CNT_W-1:0] C_H_SYNC      = P_CNT_W'(P_H_SYNC);
   localparam logic [P_CNT_W-1:0] C_V_SYNC      = P_CNT_W'(P_V_SYNC);
   localparam logic [P_CNT_W-1:0] C_H_VIS_START = P_CNT_W'(H_VIS_START);
   localparam logic [P_CNT_W-1:0] C_H_VIS_END   = P_CNT_W'(H_VIS_END);
   localparam logic [P_CNT_W-1:0] C_H_REQ_START = P_CNT_W'(H_REQ_START);
   localparam logic [P_CNT_W-1:0] C_H_REQ_END   = P_CNT_W'(H_REQ_END);
   localparam logic [P_CNT_W-1:0] C_V_VIS_START = P_CNT_W'(V_VIS_START);
   localparam logic [P_CNT_W-1:0] C_V_VIS_END   = P_CNT_W'(V_VIS_END);
   localparam logic [P_CNT_W-1:0] C_V_VBL_LINE  = P_CNT_W'(V_VBL_LINE);

   generate
      if (P_REQ_LEAD < 0 || P_REQ_LEAD > P_H_BP) begin : g_bad_lead
         $error("vga_sync_timing_param: P_REQ_LEAD must be within 0..P_H_BP");
      end
      if (P_CNT_W < 1 || P_CNT_W > 30 || (H_TOTAL - 1) >= (1 << P_CNT_W)
          || (V_TOTAL - 1) >= (1 << P_CNT_W)) begin : g_bad_width
         $error("vga_sync_timing_param: P_CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
      end
   endgenerate

   logic [P_CNT_W-1:0] r_h;
   logic [P_CNT_W-1:0] r_v;

   logic               w_h_last;
   logic               w_v_last;
   logic               w_hsync;
   logic               w_vsync;
   logic               w_hvis;
   logic               w_vvis;
   logic               w_hreq;
   logic               w_req;
   logic [P_CNT_W-1:0] w_x;
   logic [P_CNT_W-1:0] w_y;
   logic               w_h0;

   logic               r_req;
   logic [P_CNT_W-1:0] r_x;
   logic [P_CNT_W-1:0] r_y;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_blank;
   logic               r_frame_start;
   logic               r_line_start;
   logic               r_vblank_start;

   assign w_h_last = (r_h == C_H_LAST);
   assign w_v_last = (r_v == C_V_LAST);

   always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_h <= '0;
         r_v <= '0;
      end else if (iRESET_SYNC) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_h_last) begin
         r_h <= '0;
         r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   // Region decode from the current counters; registered below so outputs lag by one clock.
   always_comb begin
      w_hsync = (r_h < C_H_SYNC);
      w_vsync = (r_v < C_V_SYNC);
      w_hvis  = (r_h >= C_H_VIS_START) && (r_h < C_H_VIS_END);
      w_vvis  = (r_v >= C_V_VIS_START) && (r_v < C_V_VIS_END);
      w_hreq  = (r_h >= C_H_REQ_START) && (r_h < C_H_REQ_END);
      w_req   = w_hreq && w_vvis;
      w_x     = w_req ? (r_h - C_H_REQ_START) : '0;
      w_y     = w_req ? (r_v - C_V_VIS_START) : '0;
      w_h0    = (r_h == '0);
   end

   // oDATA_REQ is a valid-only strobe (no ready/backpressure): while high, one pixel at
   // (oDATA_REQ_X, oDATA_REQ_Y) is requested per clock; X/Y are 0 whenever it is low.
   always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_req          <= 1'b0;
         r_x            <= '0;
         r_y            <= '0;
         r_hsync        <= ~P_HS_POL;
         r_vsync        <= ~P_VS_POL;
         r_blank        <= 1'b1;
         r_frame_start  <= 1'b0;
         r_line_start   <= 1'b0;
         r_vblank_start <= 1'b0;
      end else if (iRESET_SYNC) begin
         r_req          <= 1'b0;
         r_x            <= '0;
         r_y            <= '0;
         r_hsync        <= ~P_HS_POL;
         r_vsync        <= ~P_VS_POL;
         r_blank        <= 1'b1;
         r_frame_start  <= 1'b0;
         r_line_start   <= 1'b0;
         r_vblank_start <= 1'b0;
      end else begin
         r_req          <= w_req;
         r_x            <= w_x;
         r_y            <= w_y;
         r_hsync        <= w_hsync ? P_HS_POL : ~P_HS_POL;
         r_vsync        <= w_vsync ? P_VS_POL : ~P_VS_POL;
         r_blank        <= ~(w_hvis && w_vvis);
         r_frame_start  <= w_h0 && (r_v == '0);
         r_line_start   <= w_h0;
         r_vblank_start <= w_h0 && (r_v == C_V_VBL_LINE);
      end
   end

   assign oDATA_REQ     = r_req;
   assign oDATA_REQ_X   = r_x;
   assign oDATA_REQ_Y   = r_y;
   assign oDISP_HSYNC   = r_hsync;
   assign oDISP_VSYNC   = r_vsync;
   assign oDISP_BLANK   = r_blank;
   assign oFRAME_START  = r_frame_start;
   assign oLINE_START   = r_line_start;
   assign oVBLANK_START = r_vblank_start;

endmodule

// File: tb/tb_vga_sync_timing_param.sv
// Bench for vga_sync_timing_param on a small raster (H 8/1/2/1, V 4/1/1/1, positive syncs, lead 1)
// with hand-tabulated expectations pushed to a queue and checked by a separate monitor.
module tb_vga_sync_timing_param;

   localparam int W  = 31;   // {req, x[11:0], y[11:0], hs, vs, blank, fs, ls, vbs}
   localparam int HT = 12;
   localparam int VT = 7;
   localparam logic [W-1:0] RESET_EXP = {1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 3'b000};

   logic        clk = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic        o_req;
   logic [11:0] o_x;
   logic [11:0] o_y;
   logic        o_hs;
   logic        o_vs;
   logic        o_blank;
   logic        o_fs;
   logic        o_ls;
   logic        o_vbs;

   // Hand-derived per-column / per-line tables: h 0-1 sync, 2 BP, 3-10 visible, 11 FP;
   // request with lead 1 spans h 2-9. v 0 sync, 1 BP, 2-5 visible, 6 FP.
   bit hs_t   [HT] = '{1,1,0,0,0,0,0,0,0,0,0,0};
   bit hvis_t [HT] = '{0,0,0,1,1,1,1,1,1,1,1,0};
   bit hreq_t [HT] = '{0,0,1,1,1,1,1,1,1,1,0,0};
   int x_t    [HT] = '{0,0,0,1,2,3,4,5,6,7,0,0};
   bit vs_t   [VT] = '{1,0,0,0,0,0,0};
   bit vvis_t [VT] = '{0,0,1,1,1,1,0};
   int y_t    [VT] = '{0,0,0,1,2,3,0};
   bit vbl_t  [VT] = '{0,0,0,0,0,0,1};

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;
   int n_vec  = 0;
   int n_fail = 0;
   int m_h = 0;
   int m_v = 0;

   vga_sync_timing_param #(
      .P_H_ACTIVE(8), .P_H_FP(1), .P_H_SYNC(2), .P_H_BP(1),
      .P_V_ACTIVE(4), .P_V_FP(1), .P_V_SYNC(1), .P_V_BP(1),
      .P_HS_POL(1'b1), .P_VS_POL(1'b1), .P_REQ_LEAD(1), .P_CNT_W(12)
   ) dut (
      .iVGA_CLOCK   (clk),
      .inRESET      (inRESET),
      .iRESET_SYNC  (iRESET_SYNC),
      .oDATA_REQ    (o_req),
      .oDATA_REQ_X  (o_x),
      .oDATA_REQ_Y  (o_y),
      .oDISP_HSYNC  (o_hs),
      .oDISP_VSYNC  (o_vs),
      .oDISP_BLANK  (o_blank),
      .oFRAME_START (o_fs),
      .oLINE_START  (o_ls),
      .oVBLANK_START(o_vbs)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic logic [W-1:0] exp_at(input int h, input int v);
      logic        req;
      logic [11:0] x;
      logic [11:0] y;
      logic        blank;
      req   = hreq_t[h] && vvis_t[v];
      x     = req ? 12'(x_t[h]) : 12'd0;
      y     = req ? 12'(y_t[v]) : 12'd0;
      blank = !(hvis_t[h] && vvis_t[v]);
      return {req, x, y, hs_t[h], vs_t[v], blank,
              (h == 0 && v == 0), (h == 0), (h == 0 && vbl_t[v])};
   endfunction

   function automatic logic [W-1:0] act_vec();
      return {o_req, o_x, o_y, o_hs, o_vs, o_blank, o_fs, o_ls, o_vbs};
   endfunction

   // driver: one call = one clock; expectation for the coming edge is queued here
   task automatic cycle(input bit rst_n, input bit sync);
      @(negedge clk);
      inRESET     = rst_n;
      iRESET_SYNC = sync;
      if (!rst_n || sync) begin
         exp_q.push_back(RESET_EXP);
         m_h = 0;
         m_v = 0;
      end else begin
         exp_q.push_back(exp_at(m_h, m_v));
         m_h = m_h + 1;
         if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
   endtask

   // scoreboard monitor
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = act_vec();
         n_vec++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL vec t=%0t act=%h exp=%h (req,x,y,hs,vs,blank,fs,ls,vbs)",
                     $time, mon_act, mon_exp);
         end
      end
   end

   initial begin
      logic [W-1:0] a;
      int guard;
      // reset held from time 0
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      // two complete frames plus the wrap into a third
      run(2 * HT * VT + 3);
      // walk to h=5,v=3 and pulse the synchronous restart mid-line
      guard = 0;
      while (!(m_h == 5 && m_v == 3) && guard < 200) begin
         cycle(1'b1, 1'b0);
         guard++;
      end
      if (!(m_h == 5 && m_v == 3)) begin
         n_vec++;
         n_fail++;
         $display("FAIL seek_mid_line h=%0d v=%0d required h=5 v=3", m_h, m_v);
      end
      cycle(1'b1, 1'b1);
      run(30);
      // restart held for several clocks
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
      run(40);
      // asynchronous reset mid-frame, checked between edges
      @(negedge clk);
      #2;
      inRESET = 1'b0;
      #1;
      a = act_vec();
      n_vec++;
      if (a !== RESET_EXP) begin
         n_fail++;
         $display("FAIL async_reset act=%h exp=%h", a, RESET_EXP);
      end
      m_h = 0;
      m_v = 0;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      run(HT * VT + 6);
      // drain
      repeat (2) @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
